// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, word-wide data memory, MEM/WB register.
// Exports EX/MEM forwarding and load-hazard information.
module mem_stage #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb_en,
  input  logic [4:0]  dest,
  output logic        m_fwd_en,
  output logic        m_is_load,
  output logic [4:0]  m_dest,
  output logic [31:0] m_value,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_value,
  output logic        mem_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [29:0] MaxWord = 30'(MEM_WORDS);

  logic        m_valid_q, m_valid_d, m_rd_q, m_rd_d, m_wr_q, m_wr_d, m_we_q, m_we_d;
  logic [4:0]  m_dest_q, m_dest_d;
  logic [31:0] m_addr_q, m_addr_d, m_sdata_q, m_sdata_d;

  logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_value_q, wb_value_d;
  logic        mem_err_q, mem_err_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic          is_mem, legal, illegal, mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   rdata;

  always_comb begin
    m_valid_d = ex_valid;
    m_rd_d    = mem_read;
    m_wr_d    = mem_write;
    m_we_d    = wb_en;
    m_dest_d  = dest;
    m_addr_d  = alu_result;
    m_sdata_d = store_data;
  end

  always_comb begin
    is_mem  = m_rd_q | m_wr_q;
    legal   = m_valid_q & (m_rd_q ^ m_wr_q) & (m_addr_q[1:0] == 2'b00) &
              (m_addr_q[31:2] < MaxWord);
    illegal = m_valid_q & is_mem & ~legal;
    mem_idx = m_addr_q[AW+1:2];
    rdata   = mem_q[mem_idx];
    mem_we  = legal & m_wr_q;

    wb_valid_d = m_valid_q;
    wb_we_d    = 1'b0;
    wb_dest_d  = '0;
    wb_value_d = '0;
    if (m_valid_q) begin
      wb_dest_d  = m_dest_q;
      wb_value_d = m_addr_q;
      if (legal && m_rd_q) begin
        wb_value_d = rdata;
        wb_we_d    = m_we_q;
      end else if (!is_mem) begin
        wb_we_d = m_we_q;
      end
    end
    mem_err_d = mem_err_q | illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      m_rd_q     <= 1'b0;
      m_wr_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_dest_q   <= '0;
      m_addr_q   <= '0;
      m_sdata_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_value_q <= '0;
      mem_err_q  <= 1'b0;
    end else if (!freeze) begin
      m_valid_q  <= m_valid_d;
      m_rd_q     <= m_rd_d;
      m_wr_q     <= m_wr_d;
      m_we_q     <= m_we_d;
      m_dest_q   <= m_dest_d;
      m_addr_q   <= m_addr_d;
      m_sdata_q  <= m_sdata_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_dest_q  <= wb_dest_d;
      wb_value_q <= wb_value_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Reset clears every word, so a store pending in M at reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= '0;
    end else if (!freeze && mem_we) begin
      mem_q[mem_idx] <= m_sdata_q;
    end
  end

  assign m_fwd_en  = m_valid_q & m_we_q & ~m_rd_q;
  assign m_is_load = m_valid_q & m_rd_q;
  assign m_dest    = m_dest_q;
  assign m_value   = m_addr_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_dest   = wb_dest_q;
  assign wb_value  = wb_value_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, store/load, ALU forwarding,
// illegal accesses, freeze and reset during a pending store.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, ex_valid, mem_read, mem_write, wb_en;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest;
  logic        m_fwd_en, m_is_load, wb_valid, wb_we, mem_err;
  logic [4:0]  m_dest, wb_dest;
  logic [31:0] m_value, wb_value;

  int total = 0;
  int bad = 0;

  mem_stage #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .ex_valid(ex_valid),
    .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .wb_en(wb_en), .dest(dest), .m_fwd_en(m_fwd_en),
    .m_is_load(m_is_load), .m_dest(m_dest), .m_value(m_value), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_value(wb_value), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                       input logic rd, input logic wr, input logic we,
                       input logic [4:0] d);
    ex_valid = v; alu_result = a; store_data = sd;
    mem_read = rd; mem_write = wr; wb_en = we; dest = d;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; idle();
    step();
    rst = 1'b0;
    total++;
    if ({m_fwd_en, m_is_load, m_dest, m_value, wb_valid, wb_we, wb_dest, wb_value, mem_err}
        !== '0) begin
      bad++; $display("FAIL reset_outputs: got wb_value=%h m_value=%h mem_err=%b, want all 0",
                      wb_value, m_value, mem_err);
    end
    step();
    total++;
    if ({wb_valid, m_is_load, mem_err} !== 3'b000) begin
      bad++; $display("FAIL idle_outputs: got %b, want 000", {wb_valid, m_is_load, mem_err});
    end
    drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2);
    step();
    total++;
    if (m_is_load !== 1'b1 || m_fwd_en !== 1'b0) begin
      bad++; $display("FAIL reset_load_m: got is_load=%b fwd=%b, want 1 0", m_is_load, m_fwd_en);
    end
    idle();
    step();
    total++;
    if (wb_value !== 32'h0 || wb_we !== 1'b1 || wb_dest !== 5'd2) begin
      bad++; $display("FAIL reset_load_wb: got value=%h we=%b dest=%0d, want 0 1 2",
                      wb_value, wb_we, wb_dest);
    end
  endtask

  task automatic test_store_load();
    drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    total++;
    if (m_fwd_en !== 1'b0 || m_is_load !== 1'b0) begin
      bad++; $display("FAIL store_m: got fwd=%b is_load=%b, want 0 0", m_fwd_en, m_is_load);
    end
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
    step();
    total++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      bad++; $display("FAIL store_wb: got valid=%b we=%b, want 1 0", wb_valid, wb_we);
    end
    idle();
    step();
    total++;
    if (wb_we !== 1'b1 || wb_value !== 32'hDEADBEEF || wb_dest !== 5'd4) begin
      bad++; $display("FAIL store_load_fwd: got we=%b value=%h dest=%0d, want 1 deadbeef 4",
                      wb_we, wb_value, wb_dest);
    end
    // An invalid slot carrying a store must not touch memory.
    drive(1'b0, 32'h10, 32'h12345678, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5);
    step();
    total++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      bad++; $display("FAIL invalid_slot_wb: got valid=%b we=%b, want 0 0", wb_valid, wb_we);
    end
    idle();
    step();
    total++;
    if (wb_value !== 32'hDEADBEEF) begin
      bad++; $display("FAIL invalid_slot_nowrite: got %h, want deadbeef", wb_value);
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 32'hFFFFFFFB, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7);
    step();
    total++;
    if (m_fwd_en !== 1'b1 || m_value !== 32'hFFFFFFFB || m_dest !== 5'd7) begin
      bad++; $display("FAIL alu_m: got fwd=%b value=%h dest=%0d, want 1 fffffffb 7",
                      m_fwd_en, m_value, m_dest);
    end
    idle();
    step();
    total++;
    if (wb_we !== 1'b1 || wb_dest !== 5'd7 || wb_value !== 32'hFFFFFFFB) begin
      bad++; $display("FAIL alu_wb: got we=%b dest=%0d value=%h, want 1 7 fffffffb",
                      wb_we, wb_dest, wb_value);
    end
  endtask

  task automatic test_errors();
    total++;
    if (mem_err !== 1'b0) begin
      bad++; $display("FAIL err_initial: got %b, want 0", mem_err);
    end
    drive(1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3);
    step();
    idle();
    step();
    total++;
    if (wb_we !== 1'b0 || mem_err !== 1'b1) begin
      bad++; $display("FAIL err_misaligned: got we=%b err=%b, want 0 1", wb_we, mem_err);
    end
    // 4*MEM_WORDS would alias word 0 if the range check were missing.
    drive(1'b1, 32'h400, 32'h55, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6);
    step();
    idle();
    step();
    total++;
    if (wb_value !== 32'h0 || mem_err !== 1'b1) begin
      bad++; $display("FAIL err_out_of_range: got value=%h err=%b, want 0 1", wb_value, mem_err);
    end
    // Both rd and wr set is illegal: no write to 0x10, no writeback.
    drive(1'b1, 32'h10, 32'hAAAA5555, 1'b1, 1'b1, 1'b1, 5'd8);
    step();
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
    step();
    total++;
    if (wb_we !== 1'b0) begin
      bad++; $display("FAIL err_rdwr_we: got %b, want 0", wb_we);
    end
    idle();
    step();
    total++;
    if (wb_value !== 32'hDEADBEEF) begin
      bad++; $display("FAIL err_rdwr_nowrite: got %h, want deadbeef", wb_value);
    end
    step(); step();
    total++;
    if (mem_err !== 1'b1) begin
      bad++; $display("FAIL err_sticky: got %b, want 1", mem_err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (mem_err !== 1'b0) begin
      bad++; $display("FAIL err_clear: got %b, want 0", mem_err);
    end
  endtask

  task automatic test_freeze();
    drive(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
    step();
    drive(1'b1, 32'h20, 32'h1, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    freeze = 1'b1;
    drive(1'b1, 32'h13, 32'h99, 1'b1, 1'b0, 1'b1, 5'd11);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (wb_we !== 1'b1 || wb_value !== 32'h1234 || wb_dest !== 5'd9 ||
          m_value !== 32'h20 || mem_err !== 1'b0) begin
        bad++; $display("FAIL freeze_hold%0d: got we=%b wb=%h dest=%0d m=%h err=%b, want 1 1234 9 20 0",
                        i, wb_we, wb_value, wb_dest, m_value, mem_err);
      end
    end
    freeze = 1'b0;
    idle();
    step();
    total++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      bad++; $display("FAIL freeze_release: got valid=%b we=%b, want 1 0", wb_valid, wb_we);
    end
    drive(1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1);
    step();
    idle();
    step();
    total++;
    if (wb_value !== 32'h1) begin
      bad++; $display("FAIL freeze_store: got %h, want 1", wb_value);
    end
  endtask

  task automatic test_reset_store();
    drive(1'b1, 32'h20, 32'h77, 1'b0, 1'b1, 1'b1, 5'd12);
    step();
    rst = 1'b1; freeze = 1'b1;
    idle();
    step();
    rst = 1'b0; freeze = 1'b0;
    total++;
    if ({m_fwd_en, m_is_load, m_dest, m_value, wb_valid, wb_we, wb_dest, wb_value, mem_err}
        !== '0) begin
      bad++; $display("FAIL rst_store_outputs: got m=%h wb=%h we=%b, want all 0",
                      m_value, wb_value, wb_we);
    end
    drive(1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1);
    step();
    idle();
    step();
    total++;
    if (wb_value !== 32'h0 || wb_we !== 1'b1) begin
      bad++; $display("FAIL rst_store_discard: got value=%h we=%b, want 0 1", wb_value, wb_we);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alu();
    test_errors();
    test_freeze();
    test_reset_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
